// File: rtl/pll_lock_sequencer.sv
// Reset/lock sequencer for the 50->200 MHz system PLL, running on refclk.
// Optional `PLL_LOL_COUNT_EN adds a saturating loss-of-lock counter output lol_cnt.
module pll_lock_sequencer #(
  parameter int RST_CYCLES     = 32,
  parameter int STABLE_CYCLES  = 1024,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int MAX_RETRY      = 3
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       pll_locked,
  input  logic       restart,
  output logic       pll_rst,
  output logic       ready,
  output logic       fault,
`ifdef PLL_LOL_COUNT_EN
  output logic [7:0] lol_cnt,
`endif
  output logic [3:0] retry_cnt,
  output logic [2:0] state
);

  localparam int MAX_AB  = (RST_CYCLES > STABLE_CYCLES) ? RST_CYCLES : STABLE_CYCLES;
  localparam int MAX_CNT = (MAX_AB > TIMEOUT_CYCLES) ? MAX_AB : TIMEOUT_CYCLES;
  localparam int CNT_W   = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;

  typedef enum logic [2:0] {
    RESET_HOLD = 3'd0,
    WAIT_LOCK  = 3'd1,
    STABLE     = 3'd2,
    RUN        = 3'd3,
    FAULT      = 3'd4
  } state_t;

  state_t           state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [3:0]       retry_cnt_reg;
  logic             pll_rst_reg;
  logic             ready_reg;
  logic             fault_reg;
  logic             sync1_reg;
  logic             locked_s_reg;
`ifdef PLL_LOL_COUNT_EN
  logic [7:0]       lol_cnt_reg;
`endif

  // Outputs are written alongside the state change so they always match state_reg.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state_reg     <= RESET_HOLD;
      cnt_reg       <= '0;
      retry_cnt_reg <= '0;
      pll_rst_reg   <= 1'b1;
      ready_reg     <= 1'b0;
      fault_reg     <= 1'b0;
      sync1_reg     <= 1'b0;
      locked_s_reg  <= 1'b0;
`ifdef PLL_LOL_COUNT_EN
      lol_cnt_reg   <= '0;
`endif
    end else begin
      sync1_reg    <= pll_locked;
      locked_s_reg <= sync1_reg;
      if (restart) begin
        state_reg     <= RESET_HOLD;
        cnt_reg       <= '0;
        retry_cnt_reg <= '0;
        pll_rst_reg   <= 1'b1;
        ready_reg     <= 1'b0;
        fault_reg     <= 1'b0;
      end else begin
        case (state_reg)
          RESET_HOLD: begin
            pll_rst_reg <= 1'b1;
            ready_reg   <= 1'b0;
            fault_reg   <= 1'b0;
            if (cnt_reg == CNT_W'(RST_CYCLES - 1)) begin
              state_reg   <= WAIT_LOCK;
              cnt_reg     <= '0;
              pll_rst_reg <= 1'b0;
            end else begin
              cnt_reg <= cnt_reg + 1'b1;
            end
          end
          WAIT_LOCK: begin
            if (locked_s_reg) begin
              state_reg <= STABLE;
              cnt_reg   <= '0;
            end else if (cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1)) begin
              cnt_reg     <= '0;
              pll_rst_reg <= 1'b1;
              if (retry_cnt_reg < 4'(MAX_RETRY)) begin
                retry_cnt_reg <= retry_cnt_reg + 4'd1;
                state_reg     <= RESET_HOLD;
              end else begin
                state_reg <= FAULT;
                fault_reg <= 1'b1;
              end
            end else begin
              cnt_reg <= cnt_reg + 1'b1;
            end
          end
          STABLE: begin
            // A dropout here is treated as a glitch: back to waiting, retries kept.
            if (!locked_s_reg) begin
              state_reg <= WAIT_LOCK;
              cnt_reg   <= '0;
            end else if (cnt_reg == CNT_W'(STABLE_CYCLES - 1)) begin
              state_reg <= RUN;
              cnt_reg   <= '0;
              ready_reg <= 1'b1;
            end else begin
              cnt_reg <= cnt_reg + 1'b1;
            end
          end
          RUN: begin
            if (!locked_s_reg) begin
              state_reg     <= RESET_HOLD;
              cnt_reg       <= '0;
              retry_cnt_reg <= '0;
              pll_rst_reg   <= 1'b1;
              ready_reg     <= 1'b0;
`ifdef PLL_LOL_COUNT_EN
              if (lol_cnt_reg != 8'hFF)
                lol_cnt_reg <= lol_cnt_reg + 8'd1;
`endif
            end
          end
          FAULT: begin
            pll_rst_reg <= 1'b1;
            fault_reg   <= 1'b1;
            ready_reg   <= 1'b0;
          end
          default: begin
            state_reg   <= RESET_HOLD;
            cnt_reg     <= '0;
            pll_rst_reg <= 1'b1;
            ready_reg   <= 1'b0;
            fault_reg   <= 1'b0;
          end
        endcase
      end
    end
  end

  assign pll_rst   = pll_rst_reg;
  assign ready     = ready_reg;
  assign fault     = fault_reg;
  assign retry_cnt = retry_cnt_reg;
  assign state     = state_reg;
`ifdef PLL_LOL_COUNT_EN
  assign lol_cnt   = lol_cnt_reg;
`endif

endmodule
